// File: rtl/mult_seq_pkg.sv
// Shared constants and state encoding for the shift-add multiply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mult_seq_pkg;

  // ALU operation selectors understood by the execute-stage ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b0101;

  // One shift-add step per multiplier bit
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = $clog2(ITER_COUNT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ABS_A   = 3'd1,
    ABS_B   = 3'd2,
    LOOP    = 3'd3,
    NEG_LO  = 3'd4,
    NEG_HI1 = 3'd5,
    NEG_HI2 = 3'd6,
    DONE    = 3'd7
  } state_t;

endpackage

// File: rtl/mult_seq_carry.sv
// Recovers the 32-bit adder carry-out from operand MSBs and the sum MSB.
// Latency: purely combinational.
// Backpressure: none.
module mult_seq_carry (
  input  logic x_msb,
  input  logic y_msb,
  input  logic s_msb,
  output logic carry
);

  // Carry out when both MSBs set, or one set and the sum MSB dropped to 0
  always_comb begin
    carry = (x_msb & y_msb) | ((x_msb | y_msb) & ~s_msb);
  end

endmodule

// File: rtl/mult_sequencer.sv
// Sequences the shared 32-bit ALU through shift-add steps to form a 64-bit HI/LO product.
// Latency: accept to done 33 cycles unsigned; 35/38 signed (same/differing signs).
// Backpressure: start accepted only in IDLE; requests while busy are dropped. Signed support: MULT_SEQUENCER_SIGNED_EN.
module mult_sequencer
  import mult_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_input_0,
  output logic [31:0] alu_input_1,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_output,
  input  logic        zero
);

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        mcand;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               last_iter;

`ifdef MULT_SEQUENCER_SIGNED_EN
  logic signed_q;
  logic sa;
  logic sb;
  logic lz;
`else
  // Sign request and zero flag have no consumer in the unsigned-only build
  logic unused_inputs;
  assign unused_inputs = is_signed ^ zero;
`endif

  assign last_iter = (cnt == CNT_W'(ITER_COUNT - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Carry of the LOOP add is rebuilt from MSBs since the ALU exposes only 32 bits
  mult_seq_carry u_carry (
    .x_msb (alu_input_0[31]),
    .y_msb (alu_input_1[31]),
    .s_msb (alu_output[31]),
    .carry (carry)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and ALU drive, decoded from registered state only
  always_comb begin
    state_nxt   = state;
    alu_control = ALU_ADD;
    alu_input_0 = '0;
    alu_input_1 = '0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULT_SEQUENCER_SIGNED_EN
          state_nxt = is_signed ? ABS_A : LOOP;
`else
          state_nxt = LOOP;
`endif
        end
      end
`ifdef MULT_SEQUENCER_SIGNED_EN
      ABS_A: begin
        alu_control = ALU_SUB;
        alu_input_1 = mcand;
        state_nxt   = ABS_B;
      end
      ABS_B: begin
        alu_control = ALU_SUB;
        alu_input_1 = lo;
        state_nxt   = LOOP;
      end
`endif
      LOOP: begin
        alu_input_0 = hi;
        alu_input_1 = lo[0] ? mcand : 32'd0;
        if (last_iter) begin
`ifdef MULT_SEQUENCER_SIGNED_EN
          state_nxt = (signed_q && (sa ^ sb)) ? NEG_LO : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef MULT_SEQUENCER_SIGNED_EN
      NEG_LO: begin
        alu_control = ALU_SUB;
        alu_input_1 = lo;
        state_nxt   = NEG_HI1;
      end
      NEG_HI1: begin
        alu_control = ALU_NOR;
        alu_input_0 = hi;
        state_nxt   = NEG_HI2;
      end
      NEG_HI2: begin
        alu_input_0 = hi;
        alu_input_1 = {31'd0, lz};
        state_nxt   = DONE;
      end
`endif
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Product datapath: operand capture, magnitude fixup, shift-add, negation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= op_a;
            lo    <= op_b;
            hi    <= '0;
            cnt   <= '0;
          end
        end
`ifdef MULT_SEQUENCER_SIGNED_EN
        ABS_A: begin
          if (mcand[31]) mcand <= alu_output;
        end
        ABS_B: begin
          if (lo[31]) lo <= alu_output;
        end
`endif
        LOOP: begin
          hi  <= {carry, alu_output[31:1]};
          lo  <= {alu_output[0], lo[31:1]};
          cnt <= cnt + CNT_W'(1);
        end
`ifdef MULT_SEQUENCER_SIGNED_EN
        NEG_LO: begin
          lo <= alu_output;
        end
        NEG_HI1, NEG_HI2: begin
          hi <= alu_output;
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifdef MULT_SEQUENCER_SIGNED_EN
  // Sign bookkeeping: request type, operand signs, and whether negated lo wrapped to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signed_q <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      lz       <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start) signed_q <= is_signed;
        ABS_A:   sa <= mcand[31];
        ABS_B:   sb <= lo[31];
        NEG_LO:  lz <= zero;
        default: begin
        end
      endcase
    end
  end
`endif

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle multiply controller that computes a 64-bit HI/LO product by sequencing the existing combinational 32-bit ALU through repeated shift-add steps. It sits beside the ALU in the execute stage and owns the ALU's operand and control inputs while busy. It lets the core support MULT/MULTU without adding a dedicated multiplier array.

## Interface
- No parameters; datapath width fixed at 32 to match the ALU.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only in IDLE
- is_signed  in  1  sampled with start; 1 = MULT, 0 = MULTU
- op_a  in  32  multiplicand, sampled on accept
- op_b  in  32  multiplier, sampled on accept
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; hi/lo valid
- hi  out  32  product[63:32], held until next accept
- lo  out  32  product[31:0], held until next accept
- alu_input_0  out  32  ALU operand 0
- alu_input_1  out  32  ALU operand 1
- alu_control  out  4  ALU op: ADD 0010, SUB 0110, NOR 0101
- alu_output  in  32  ALU result, same cycle (combinational path)
- zero  in  1  ALU zero flag

## Operation
- States: IDLE, ABS_A, ABS_B, LOOP, NEG_LO, NEG_HI1, NEG_HI2, DONE.
- IDLE: drives ADD with both operands 0.
- start in IDLE latches the operands and is_signed, clears hi to 0 and iteration count cnt to 0, then moves to ABS_A when signed, otherwise to LOOP. start outside IDLE is ignored.
- ABS_A: ALU SUB(0, a). Register mcand = a[31] ? alu_output : a. Record sa = a[31].
- ABS_B: same for b into lo. Record sb = b[31]. Next state: LOOP.
- LOOP, one iteration per cycle, always ALU ADD:
  - Operands: input_0 = hi, input_1 = lo[0] ? mcand : 0.
  - Carry out c = (x31 & y31) | ((x31 | y31) & ~s31), where x, y are the two operands and s is the sum.
  - Update hi <= {c, s[31:1]}, lo <= {s[0], lo[31:1]}, cnt++.
  - After the iteration with cnt == 31: go to NEG_LO if signed and sa^sb, else DONE.
- NEG_LO: ALU SUB(0, lo) → lo. Register lz = zero of the original lo, i.e. ALU zero of the result.
- NEG_HI1: ALU NOR(hi, 0) → hi.
- NEG_HI2: ALU ADD(hi, {31'b0, lz}) → hi. Next state: DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- All arithmetic is modulo 2^32 per ALU op. The 64-bit result is exact for all inputs, including 0x80000000 operands, because magnitudes are treated as unsigned.

## Timing
- Reset values (asynchronous, immediate): state IDLE; busy 0, done 0, hi 0, lo 0, cnt 0; alu_control 0010, alu_input_0 0, alu_input_1 0.
- Accept at edge 0. LOOP occupies 32 cycles.
- done is asserted in the cycle after the final state's edge. Accept to done:
  - unsigned: 33 cycles.
  - signed, same signs: 35 cycles.
  - signed, differing signs: 38 cycles.
- busy rises the cycle after accept and falls when DONE → IDLE. busy and done are high together in DONE.
- A new start is legal in the cycle after done (IDLE). No back-to-back accept in the DONE cycle.
- rst_n asserted mid-operation aborts immediately. Partial results are discarded, hi/lo return to 0, and no done is generated.
- ALU outputs are fully determined by registered state. No combinational path from start to the ALU ports.

## Configuration
- MULT_SEQUENCER_SIGNED_EN defined:
  - is_signed honoured.
  - ABS_A, ABS_B, NEG_LO, NEG_HI1 and NEG_HI2 are present.
- Undefined:
  - is_signed is ignored and every request is MULTU.
  - The five sign states and the sa, sb, lz registers are removed. alu_control only ever drives ADD.
  - Latency is always 33.

## Structure
- Package mult_seq_pkg:
  - ALU control localparams: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 0101.
  - State enum.
  - Iteration count constant (32).
- Sub-module mult_seq_carry: pure combinational carry-out reconstruction from the two operand MSBs and the sum MSB.
- The ALU itself is instantiated outside this block.

## Test plan
- Unsigned 7 × 6 → hi 0x00000000, lo 0x0000002A; done exactly 33 cycles after accept.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi 0xFFFFFFFE, lo 0x00000001 (exercises the carry path every iteration).
- Signed −3 × 5 → hi 0xFFFFFFFF, lo 0xFFFFFFF1; latency 38.
- Signed 0x80000000 × 0x80000000 → hi 0x40000000, lo 0x00000000; latency 35. Signed −1 × 0 → hi 0, lo 0; latency 38.
- start pulsed while busy is ignored, and the result equals the first request. rst_n low at LOOP cnt 10 → busy 0, hi/lo 0, no done. A following 2 × 3 → lo 6.
- Macro undefined: is_signed = 1 with −1 × −1 → hi 0xFFFFFFFE, lo 0x00000001; latency 33.
